// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator's sequential arithmetic unit.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 16;
    localparam int unsigned CALC_CNT_W = 5;
    localparam int unsigned OP_W       = 2;
    localparam int unsigned ST_W       = 2;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
    localparam op_t OP_DIV = 2'b11;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MUL and DIV iterate one bit per cycle; ADD and SUB finish in one cycle
    function automatic logic is_iterative(input op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/calc_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
module calc_muldiv_step
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   work_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   work_nxt_c
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_trial;

    // MUL: work = {partial product, remaining multiplier bits}, shifting right.
    // DIV: work = {remainder, dividend/quotient bits}, shifting left.
    always_comb begin
        mul_sum    = {1'b0, work_i[2*WIDTH-1:WIDTH]}
                   + (work_i[0] ? {1'b0, opnd_i} : (WIDTH+1)'(0));
        div_trial  = work_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
        work_nxt_c = {mul_sum, work_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (!div_trial[WIDTH]) begin
                work_nxt_c = {div_trial[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
            end else begin
                work_nxt_c = {work_i[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/calc_seq_alu.sv
// Multi-cycle ADD/SUB/MUL/DIV unit feeding the calculator accumulator.
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH,
    parameter int unsigned CNT_W = CALC_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             acc_w,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             dz
);

    state_e               state_q,  state_d;
    op_t                  op_q,     op_d;
    logic [WIDTH-1:0]     a_q,      a_d;
    logic [WIDTH-1:0]     b_q,      b_d;
    logic [2*WIDTH-1:0]   work_q,   work_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 ovf_q,    ovf_d;
    logic                 dz_q,     dz_d;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic                 last_iter;
    logic [WIDTH-1:0]     step_opnd;
    logic [2*WIDTH-1:0]   work_nxt_c;

    // Multiplicand for MUL, divisor for DIV
    assign step_opnd = (op_q == OP_MUL) ? a_q : b_q;

    calc_muldiv_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .is_div_i   (op_q == OP_DIV),
        .work_i     (work_q),
        .opnd_i     (step_opnd),
        .work_nxt_c (work_nxt_c)
    );

    assign add_sum   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff  = {1'b0, a_q} - {1'b0, b_q};
    assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    a_d    = a;
                    b_d    = b;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    dz_d   = 1'b0;
                    work_d = (op == OP_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
                    if (op == OP_DIV && b == '0) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                        dz_d     = 1'b1;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (!is_iterative(op_q)) begin
                    state_d = ST_DONE;
                    if (op_q == OP_ADD) begin
                        result_d = add_sum[WIDTH-1:0];
                        ovf_d    = add_sum[WIDTH];
                    end else begin
                        result_d = sub_diff[WIDTH-1:0];
                        ovf_d    = sub_diff[WIDTH];
                    end
                end else begin
                    work_d = work_nxt_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d  = ST_DONE;
                        result_d = work_nxt_c[WIDTH-1:0];
                        ovf_d    = (op_q == OP_MUL) ? (|work_nxt_c[2*WIDTH-1:WIDTH]) : 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign acc_w  = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Directed and random checks of calc_seq_alu with an expected-result queue.
module tb_calc_seq_alu;
    import calc_pkg::*;

    localparam int unsigned W = 16;

    logic         CLK;
    logic         RESET;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         acc_w;
    logic [W-1:0] result;
    logic         ovf;
    logic         dz;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    calc_seq_alu #(.WIDTH(16), .CNT_W(5)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .acc_w  (acc_w),
        .result (result),
        .ovf    (ovf),
        .dz     (dz)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [2*W-1:0] p;
        e = '0;
        case (o)
            OP_ADD: begin p = 32'(x) + 32'(y); e.res = p[W-1:0]; e.ovf = p[W]; end
            OP_SUB: begin e.res = x - y; e.ovf = (x < y); end
            OP_MUL: begin p = 32'(x) * 32'(y); e.res = p[W-1:0]; e.ovf = (p[2*W-1:W] != 0); end
            default: begin
                if (y == 0) e.dz = 1'b1;
                else        e.res = x / y;
            end
        endcase
        return e;
    endfunction

    // Steps negedge by negedge until done is seen or the budget runs out
    task automatic wait_done(output int edges, output logic busy_ok);
        edges   = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && edges < 40) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            busy_ok = busy_ok && (busy === 1'b1);
        end
    endtask

    task automatic check_pulse(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_ovf"},    32'(ovf),    32'(e.ovf));
            check({tag, "_dz"},     32'(dz),     32'(e.dz));
        end
        check({tag, "_acc_w"}, 32'(acc_w), 32'd1);
    endtask

    task automatic finish_op(input string tag, input int lat_exp, input int pre_edges);
        int   e;
        logic bok;
        wait_done(e, bok);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"},   32'(pre_edges + e), 32'(lat_exp));
        check({tag, "_busy"},      32'(bok), 32'd1);
        check_pulse(tag);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the done pulse
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input exp_t e, input int lat);
        start = 1'b1; op = o; a = x; b = y;
        sb_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        finish_op(tag, lat, 1);
        @(negedge CLK);
        check({tag, "_done_pulse"}, 32'(done),   32'd0);
        check({tag, "_acc_w_low"},  32'(acc_w),  32'd0);
        check({tag, "_idle"},       32'(busy),   32'd0);
        check({tag, "_hold"},       32'(result), 32'(e.res));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   ed;
        logic bok;
        logic [1:0]   ro;
        logic [W-1:0] rx, ry;

        start = 1'b0; op = 2'b00; a = '0; b = '0;
        RESET = 1'b1;
        #1 RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_acc_w",  32'(acc_w),  32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf",    32'(ovf),    32'd0);
        check("rst_dz",     32'(dz),     32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        e = '{res: 16'h72B3, ovf: 1'b0, dz: 1'b0}; run_op("add1", OP_ADD, 16'h6AB3, 16'h0800, e, 2);
        e = '{res: 16'h0000, ovf: 1'b1, dz: 1'b0}; run_op("add2", OP_ADD, 16'hFFFF, 16'h0001, e, 2);
        e = '{res: 16'hF900, ovf: 1'b1, dz: 1'b0}; run_op("sub1", OP_SUB, 16'h0800, 16'h0F00, e, 2);
        e = '{res: 16'h0700, ovf: 1'b0, dz: 1'b0}; run_op("sub2", OP_SUB, 16'h0F00, 16'h0800, e, 2);
        e = '{res: 16'h1200, ovf: 1'b0, dz: 1'b0}; run_op("mul1", OP_MUL, 16'h0100, 16'h0012, e, 17);
        e = '{res: 16'h0000, ovf: 1'b1, dz: 1'b0}; run_op("mul2", OP_MUL, 16'h0100, 16'h0100, e, 17);
        e = '{res: 16'h06AB, ovf: 1'b0, dz: 1'b0}; run_op("div1", OP_DIV, 16'h6AB3, 16'h0010, e, 17);
        e = '{res: 16'h0000, ovf: 1'b0, dz: 1'b1}; run_op("div0", OP_DIV, 16'h6AB3, 16'h0000, e, 1);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (i == 4) begin ro = OP_DIV; ry = 16'h0001 | ry; end
            if (i == 5) begin ro = OP_MUL; end
            run_op("rand", ro, rx, ry, model(ro, rx, ry),
                   (ro == OP_DIV && ry == 0) ? 1 : (ro[1] ? 17 : 2));
        end

        // Reset in the middle of a multiply
        start = 1'b1; op = OP_MUL; a = 16'h1234; b = 16'h5678;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        check("mid_rst_busy",   32'(busy),   32'd0);
        check("mid_rst_done",   32'(done),   32'd0);
        check("mid_rst_acc_w",  32'(acc_w),  32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_ovf",    32'(ovf),    32'd0);
        check("mid_rst_dz",     32'(dz),     32'd0);
        #1 RESET = 1'b1;
        @(negedge CLK);
        e = '{res: 16'h0003, ovf: 1'b0, dz: 1'b0}; run_op("post_rst_add", OP_ADD, 16'h0001, 16'h0002, e, 2);

        // start pulses while busy are ignored; held start is taken on the first IDLE edge
        start = 1'b1; op = OP_MUL; a = 16'h0003; b = 16'h0005;
        sb_q.push_back(model(OP_MUL, 16'h0003, 16'h0005));
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        start = 1'b1; op = OP_ADD; a = 16'hAAAA; b = 16'h5555;
        @(negedge CLK);
        start = 1'b0; a = '0; b = '0;
        finish_op("busy_ign_mul", 17, 6);
        start = 1'b1; op = OP_ADD; a = 16'h1000; b = 16'h0234;
        sb_q.push_back('{res: 16'h1234, ovf: 1'b0, dz: 1'b0});
        @(negedge CLK);
        check("idle_gap_busy", 32'(busy), 32'd0);
        check("idle_gap_done", 32'(done), 32'd0);
        @(negedge CLK);
        start = 1'b0;
        check("held_accept_busy", 32'(busy), 32'd1);
        wait_done(ed, bok);
        check("b2b_done_seen", 32'(done), 32'd1);
        check("b2b_latency",   32'(ed),   32'd1);
        check_pulse("b2b_add");
        @(negedge CLK);
        check("final_idle", 32'(busy), 32'd0);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
- Multi-cycle arithmetic unit of the pocket calculator, directly upstream of the accumulator register.
- Takes the current accumulator value and a keypad-entered operand, and executes ADD, SUB, MUL or DIV.
- Drives the accumulator's data input and write strobe with a one-cycle pulse when the result is ready.
- ADD/SUB complete in one compute cycle; MUL/DIV are iterative (shift-add / restoring), one bit per cycle.

Parameters:
- WIDTH, 16, operand/result width (matches the accumulator data width).
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled with start.
- a  in  WIDTH  left operand (accumulator output); latched on accepted start.
- b  in  WIDTH  right operand (entered number); latched on accepted start.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse, result valid.
- acc_w  out  1  accumulator write strobe; identical to done.
- result  out  WIDTH  to accumulator data input; holds its value until the next done.
- ovf  out  1  carry (ADD), borrow (SUB), or nonzero upper product half (MUL); valid with done, held.
- dz  out  1  divide by zero; valid with done, held.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; counter=0; internal operand/remainder regs=0.
  - busy=0, done=0, acc_w=0, result=0, ovf=0, dz=0.
  - Takes effect mid-operation: any partial computation is discarded.
- States: IDLE, CALC, DONE (encoding defined in the package).
- IDLE:
  - On a rising edge with start=1: latch a, b, op; clear counter; clear ovf and dz.
  - Next state is CALC, except DIV with b==0.
  - DIV with b==0: next state DONE, result=0, dz=1. Latency 1 edge.
  - start=0: remain in IDLE.
- CALC, ADD/SUB:
  - Single cycle: result = (a ± b) mod 2^WIDTH; ovf = carry-out for ADD, borrow for SUB.
  - Next state DONE. Done appears 2 edges after the start edge.
- CALC, MUL (unsigned shift-add):
  - 2*WIDTH-bit product register, one multiplier bit per cycle, WIDTH cycles.
  - result = low WIDTH bits; ovf = 1 if the high half is nonzero.
  - Done appears WIDTH+1 = 17 edges after the start edge.
- CALC, DIV (unsigned restoring):
  - One quotient bit per cycle, WIDTH cycles.
  - result = quotient; remainder is discarded; ovf = 0.
  - Done appears 17 edges after the start edge.
- Counter:
  - Increments each CALC cycle for MUL/DIV.
  - Leaves CALC when counter == WIDTH-1 at the edge; never wraps.
- DONE:
  - done=acc_w=1 for exactly this one cycle.
  - Unconditional return to IDLE at the next edge.
  - start asserted during DONE is ignored; the earliest new accept is the following IDLE edge.
- start while busy: ignored; latched operands are unaffected by any change on a, b or op.
- Back-to-back: with start held high, a new op is accepted on the first IDLE edge, giving one idle cycle between consecutive done pulses.
- Outputs in IDLE:
  - result, ovf and dz hold their last values.
  - done and acc_w stay 0 except during DONE.
- All arithmetic is unsigned; there is no sign handling.

Decomposition:
- Package calc_pkg:
  - WIDTH default.
  - Opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - State encoding constants ST_IDLE, ST_CALC, ST_DONE.
- One natural sub-module, calc_muldiv_step: combinational single-iteration datapath.
  - Shift-add step for MUL and restore-subtract step for DIV, selected by op.
  - Instantiated once; the FSM and registers stay in calc_seq_alu.

Test Plan:
1. ADD a=0x6AB3, b=0x0800 -> result=0x72B3, ovf=0; done/acc_w high for exactly 1 cycle, 2 edges after the start edge. Then a=0xFFFF, b=0x0001 -> result=0x0000, ovf=1.
2. SUB a=0x0800, b=0x0F00 -> result=0xF900, ovf=1. Then a=0x0F00, b=0x0800 -> result=0x0700, ovf=0.
3. MUL a=0x0100, b=0x0012 -> result=0x1200, ovf=0; done 17 edges after start, busy high throughout. Then a=0x0100, b=0x0100 -> result=0x0000, ovf=1.
4. DIV a=0x6AB3, b=0x0010 -> result=0x06AB, dz=0, 17-edge latency. Then b=0x0000 -> result=0x0000, dz=1, done 1 edge after start.
5. Start MUL; pulse RESET=0 between edges after 8 CALC cycles -> all outputs 0 immediately, without waiting for a clock. Release reset, then ADD 0x0001+0x0002 -> result=0x0003.
6. Start MUL; pulse start with op=ADD and new a/b during CALC and during DONE -> both ignored, MUL result correct. Hold start high -> next op accepted exactly 1 cycle after DONE.
